uart_fifo_param: RTL and testbench
==================================

UART_FIFO_PARAM -- requirements
Module: uart_fifo_param

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLK (clock), RESET (reset); no other clock or reset exists.
REQ-002 Parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 8, word width in bits.
- DEPTH, 128, storage words, 2..1024; powers of two are not required.
- AFULL_TH, DEPTH-4, almost-full threshold, 1..DEPTH.
- AEMPTY_TH, 4, almost-empty threshold, 0..DEPTH-1.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- CLK, in, 1, clock.
- RESET, in, 1, synchronous active-high reset.
- DATA_IN, in, DATA_WIDTH, write data.
- WRB, in, 1, write strobe, active-low.
- RDB, in, 1, read strobe, active-low.
- CLR_ERR, in, 1, clears the sticky error flags.
- DATA_OUT, out, DATA_WIDTH, read data.
- FULL, out, 1, COUNT == DEPTH.
- EMPTY, out, 1, COUNT == 0.
- AFULL, out, 1, COUNT >= AFULL_TH.
- AEMPTY, out, 1, COUNT <= AEMPTY_TH.
- COUNT, out, CW = clog2(DEPTH+1), words stored.
- OVERFLOW, out, 1, sticky write-when-full flag.
- UNDERFLOW, out, 1, sticky read-when-empty flag.

Function
REQ-004 A write SHALL be accepted on a rising CLK edge when WRB=0 and FULL=0, storing DATA_IN at the write pointer.
REQ-005 A read SHALL be accepted when RDB=0 and EMPTY=0, advancing the read pointer.
REQ-006 Both pointers SHALL wrap from DEPTH-1 to 0, including for non-power-of-two DEPTH.
REQ-007 COUNT SHALL change as follows: +1 on write only, -1 on read only, unchanged on both or neither. COUNT SHALL never exceed DEPTH or go below 0.
REQ-008 When FULL=1, a write SHALL be rejected even if a read is accepted in the same cycle. The read SHALL complete and FULL SHALL deassert next cycle.
REQ-009 When EMPTY=1, a read SHALL be rejected even if a write is accepted in the same cycle.
REQ-010 A rejected write (WRB=0 with FULL=1) SHALL set OVERFLOW the next cycle. A rejected read SHALL likewise set UNDERFLOW. Memory, pointers and COUNT SHALL be unaffected by a rejected access.
REQ-011 CLR_ERR=1 SHALL clear OVERFLOW and UNDERFLOW the next cycle. If an error event occurs in the same cycle, the set wins.
REQ-012 FULL, EMPTY, AFULL and AEMPTY SHALL be derived only from registered COUNT; no flag depends combinationally on WRB or RDB.
REQ-013 FWFT=0: DATA_OUT SHALL load the head word on the edge after an accepted read (1-cycle latency) and hold its value otherwise.
REQ-014 FWFT=1: whenever EMPTY=0, DATA_OUT SHALL present the head word. An accepted read SHALL expose the next word in the following cycle. A write into an empty FIFO SHALL appear on DATA_OUT in the same cycle EMPTY falls.
REQ-015 Out-of-range parameters SHALL stop elaboration with an error.

Reset
REQ-016 RESET=1 at a CLK edge SHALL set the pointers and COUNT to 0, DATA_OUT to 0, EMPTY=1, AEMPTY=1, and FULL, AFULL, OVERFLOW and UNDERFLOW to 0. Storage contents are not cleared.
REQ-017 RESET SHALL override any simultaneous write, read or CLR_ERR, including mid-burst. The first access is accepted on the first edge with RESET=0.

Structure
REQ-018 The shared package uart_fifo_pkg SHALL hold the clog2 width function, the parameter range limits and the default constants.
REQ-019 Storage SHALL be the sub-module uart_fifo_ram: simple dual-port, DEPTH x DATA_WIDTH, synchronous write, asynchronous read.
REQ-020 Pointer, count, flag and output-register logic SHALL live in uart_fifo_param.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then fill: DEPTH=8, FWFT=0, write 0x01..0x08 -> COUNT 1..8, AFULL at COUNT=4 (AFULL_TH=4), FULL after 8th write, OVERFLOW=0.
- Overflow: 9th write with FULL=1 -> OVERFLOW=1, COUNT=8, contents unchanged; CLR_ERR pulse -> OVERFLOW=0.
- Drain and wrap: read 8 -> DATA_OUT 0x01..0x08, each 1 cycle after its read; EMPTY=1; write/read 20 more words -> order preserved across wrap.
- Simultaneous access: at COUNT=3, WRB=RDB=0 for 5 cycles -> COUNT stays 3. At FULL, both low -> read done, write rejected, OVERFLOW=1, COUNT=7.
- FWFT=1, DEPTH=6: write 0xA5 into empty -> EMPTY falls and DATA_OUT=0xA5 in the same cycle. Read on empty -> UNDERFLOW=1, COUNT=0.
- Reset mid-burst: RESET=1 during a write stream at COUNT=5 -> COUNT=0, EMPTY=1, DATA_OUT=0 next edge; flags cleared.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// Shared constants and width helper for the uart_fifo_param FIFO slice.
package uart_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 128;
  localparam int AFULL_MARGIN   = 4;
  localparam int DEF_AEMPTY_TH  = 4;
  localparam int DEF_FWFT       = 0;

  localparam int DEPTH_MIN      = 2;
  localparam int DEPTH_MAX      = 1024;
  localparam int DATA_WIDTH_MIN = 1;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
// Read data follows raddr_i combinationally; there is no backpressure.
module uart_fifo_ram
  import uart_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  localparam int AW         = clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_fifo_param.sv
// Parameterised synchronous FIFO with sticky error flags; 1-cycle registered read or FWFT.
// Writes when FULL and reads when EMPTY are dropped and flagged, never stalled.
module uart_fifo_param
  import uart_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int AFULL_TH   = DEPTH - AFULL_MARGIN,
  parameter  int AEMPTY_TH  = DEF_AEMPTY_TH,
  parameter  int FWFT       = DEF_FWFT,
  localparam int CW         = clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  WRB,
  input  logic                  RDB,
  input  logic                  CLR_ERR,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  AFULL,
  output logic                  AEMPTY,
  output logic [CW-1:0]         COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int PW = clog2(DEPTH);

  if (DATA_WIDTH < DATA_WIDTH_MIN) begin : g_bad_width
    $error("uart_fifo_param: DATA_WIDTH must be >= 1");
  end
  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("uart_fifo_param: DEPTH must be within 2..1024");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("uart_fifo_param: AFULL_TH must be within 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("uart_fifo_param: AEMPTY_TH must be within 0..DEPTH-1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("uart_fifo_param: FWFT must be 0 or 1");
  end

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;

  // Explicit wrap so non-power-of-two depths never address past the array.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_acc = ~WRB & ~full;
  assign rd_acc = ~RDB & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rd_acc) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      dout_d   = ram_rdata;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A new error event in the clearing cycle keeps the flag set.
    ovf_d = (~WRB & full)  | (ovf_q & ~CLR_ERR);
    unf_d = (~RDB & empty) | (unf_q & ~CLR_ERR);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
    end
  end

  uart_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (DATA_IN),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  if (FWFT == 1) begin : g_fwft
    assign DATA_OUT = empty ? '0 : ram_rdata;
  end else begin : g_reg
    assign DATA_OUT = dout_q;
  end

  assign FULL      = full;
  assign EMPTY     = empty;
  assign AFULL     = (count_q >= CW'(AFULL_TH));
  assign AEMPTY    = (count_q <= CW'(AEMPTY_TH));
  assign COUNT     = count_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;

endmodule

// File: tb/tb_uart_fifo_param.sv
// Directed bench: registered-read FIFO (DEPTH=8) checked through a read scoreboard,
// FWFT FIFO (DEPTH=6) checked against a queue model every cycle.
module tb_uart_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: DEPTH=8, FWFT=0, AFULL_TH=4, AEMPTY_TH=4
  logic       a_reset = 1'b1, a_wrb = 1'b1, a_rdb = 1'b1, a_clr = 1'b0;
  logic [7:0] a_din = '0, a_dout;
  logic       a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf;
  logic [3:0] a_count;

  // Instance B: DEPTH=6, FWFT=1, AFULL_TH=2 (DEPTH-4), AEMPTY_TH=4
  logic       b_reset = 1'b1, b_wrb = 1'b1, b_rdb = 1'b1, b_clr = 1'b0;
  logic [7:0] b_din = '0, b_dout;
  logic       b_full, b_empty, b_afull, b_aempty, b_ovf, b_unf;
  logic [2:0] b_count;

  uart_fifo_param #(.DATA_WIDTH(8), .DEPTH(8), .AFULL_TH(4), .AEMPTY_TH(4), .FWFT(0)) u_a (
    .CLK(clk), .RESET(a_reset), .DATA_IN(a_din), .WRB(a_wrb), .RDB(a_rdb), .CLR_ERR(a_clr),
    .DATA_OUT(a_dout), .FULL(a_full), .EMPTY(a_empty), .AFULL(a_afull), .AEMPTY(a_aempty),
    .COUNT(a_count), .OVERFLOW(a_ovf), .UNDERFLOW(a_unf)
  );

  uart_fifo_param #(.DATA_WIDTH(8), .DEPTH(6), .FWFT(1)) u_b (
    .CLK(clk), .RESET(b_reset), .DATA_IN(b_din), .WRB(b_wrb), .RDB(b_rdb), .CLR_ERR(b_clr),
    .DATA_OUT(b_dout), .FULL(b_full), .EMPTY(b_empty), .AFULL(b_afull), .AEMPTY(b_aempty),
    .COUNT(b_count), .OVERFLOW(b_ovf), .UNDERFLOW(b_unf)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard for instance A: expected read words, checked one cycle after each read.
  logic [7:0] a_mdl [$];
  logic [7:0] sb_q  [$];
  logic [7:0] sb_e;
  bit         a_movf = 1'b0, a_munf = 1'b0;
  bit         rd_exp = 1'b0, rd_pend = 1'b0;

  always @(posedge clk) rd_pend <= rd_exp;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_pop: DATA_OUT 0x%0h presented with no expected word", a_dout);
      end else begin
        sb_e = sb_q.pop_front();
        chk("sb_dout", int'(a_dout), int'(sb_e));
      end
    end
  end

  task automatic a_cycle(input bit rst, input bit wr, input logic [7:0] din, input bit rd, input bit clr);
    int cnt = a_mdl.size();
    bit wr_ok, rd_ok;
    wr_ok   = wr && (cnt < 8);
    rd_ok   = rd && (cnt > 0);
    a_reset = rst;
    a_wrb   = ~wr;
    a_rdb   = ~rd;
    a_din   = din;
    a_clr   = clr;
    rd_exp  = rd_ok && !rst;
    @(posedge clk);
    #1;
    if (rst) begin
      a_mdl.delete();
      a_movf = 1'b0;
      a_munf = 1'b0;
    end else begin
      if (rd_ok) sb_q.push_back(a_mdl.pop_front());
      if (wr_ok) a_mdl.push_back(din);
      a_movf = (wr && !wr_ok) || (a_movf && !clr);
      a_munf = (rd && !rd_ok) || (a_munf && !clr);
    end
    rd_exp  = 1'b0;
    a_reset = 1'b0;
    a_wrb   = 1'b1;
    a_rdb   = 1'b1;
    a_clr   = 1'b0;
  endtask

  task automatic a_chk(input string tag);
    int n = a_mdl.size();
    chk({tag, " count"},  int'(a_count),  n);
    chk({tag, " full"},   int'(a_full),   int'(n == 8));
    chk({tag, " empty"},  int'(a_empty),  int'(n == 0));
    chk({tag, " afull"},  int'(a_afull),  int'(n >= 4));
    chk({tag, " aempty"}, int'(a_aempty), int'(n <= 4));
    chk({tag, " ovf"},    int'(a_ovf),    int'(a_movf));
    chk({tag, " unf"},    int'(a_unf),    int'(a_munf));
  endtask

  // Instance B model: FWFT head is always the front of the queue.
  logic [7:0] b_mdl [$];
  bit         b_movf = 1'b0, b_munf = 1'b0;

  task automatic b_cycle(input bit rst, input bit wr, input logic [7:0] din, input bit rd);
    int cnt = b_mdl.size();
    bit wr_ok, rd_ok;
    wr_ok   = wr && (cnt < 6);
    rd_ok   = rd && (cnt > 0);
    b_reset = rst;
    b_wrb   = ~wr;
    b_rdb   = ~rd;
    b_din   = din;
    @(posedge clk);
    #1;
    if (rst) begin
      b_mdl.delete();
      b_movf = 1'b0;
      b_munf = 1'b0;
    end else begin
      if (rd_ok) void'(b_mdl.pop_front());
      if (wr_ok) b_mdl.push_back(din);
      b_movf = (wr && !wr_ok) || b_movf;
      b_munf = (rd && !rd_ok) || b_munf;
    end
    b_reset = 1'b0;
    b_wrb   = 1'b1;
    b_rdb   = 1'b1;
  endtask

  task automatic b_chk(input string tag);
    int n = b_mdl.size();
    chk({tag, " count"},  int'(b_count),  n);
    chk({tag, " empty"},  int'(b_empty),  int'(n == 0));
    chk({tag, " full"},   int'(b_full),   int'(n == 6));
    chk({tag, " afull"},  int'(b_afull),  int'(n >= 2));
    chk({tag, " aempty"}, int'(b_aempty), int'(n <= 4));
    chk({tag, " ovf"},    int'(b_ovf),    int'(b_movf));
    chk({tag, " unf"},    int'(b_unf),    int'(b_munf));
    chk({tag, " dout"},   int'(b_dout),   (n == 0) ? 0 : int'(b_mdl[0]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- Instance A ----------------
    a_cycle(1, 0, 8'h00, 0, 0);
    a_cycle(1, 0, 8'h00, 0, 0);
    a_chk("a_reset");
    chk("a_reset dout", int'(a_dout), 0);

    for (int i = 1; i <= 8; i++) begin
      a_cycle(0, 1, 8'(i), 0, 0);
      a_chk("a_fill");
      chk("a_fill count", int'(a_count), i);
      chk("a_fill afull", int'(a_afull), int'(i >= 4));
    end
    chk("a_fill full", int'(a_full), 1);
    chk("a_fill ovf", int'(a_ovf), 0);

    a_cycle(0, 1, 8'h99, 0, 0);
    a_chk("a_ovf");
    chk("a_ovf flag", int'(a_ovf), 1);
    chk("a_ovf count", int'(a_count), 8);
    a_cycle(0, 0, 8'h00, 0, 1);
    chk("a_clr ovf", int'(a_ovf), 0);

    for (int i = 0; i < 8; i++) begin
      a_cycle(0, 0, 8'h00, 1, 0);
      a_chk("a_drain");
    end
    a_cycle(0, 0, 8'h00, 0, 0);
    a_cycle(0, 0, 8'h00, 0, 0);
    chk("a_drain hold dout", int'(a_dout), 8'h08);
    chk("a_drain empty", int'(a_empty), 1);

    for (int i = 0; i < 20; i++) begin
      a_cycle(0, 1, 8'(8'h40 + i), 0, 0);
      a_cycle(0, 0, 8'h00, 1, 0);
    end
    a_chk("a_wrap");

    for (int i = 0; i < 3; i++) a_cycle(0, 1, 8'(8'h61 + i), 0, 0);
    for (int k = 0; k < 5; k++) begin
      a_cycle(0, 1, 8'(8'h70 + k), 1, 0);
      chk("a_simul count", int'(a_count), 3);
    end
    for (int i = 0; i < 5; i++) a_cycle(0, 1, 8'(8'h80 + i), 0, 0);
    chk("a_simul full", int'(a_full), 1);
    a_cycle(0, 1, 8'hEE, 1, 0);
    a_chk("a_simfull");
    chk("a_simfull count", int'(a_count), 7);
    chk("a_simfull ovf", int'(a_ovf), 1);
    chk("a_simfull full", int'(a_full), 0);
    a_cycle(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 7; i++) a_cycle(0, 0, 8'h00, 1, 0);
    a_chk("a_simdrain");

    a_cycle(0, 0, 8'h00, 1, 0);
    a_chk("a_unf");
    chk("a_unf flag", int'(a_unf), 1);

    for (int i = 0; i < 6; i++) a_cycle(0, 1, 8'(8'hC0 + i), 0, 0);
    a_cycle(0, 1, 8'hC6, 1, 0);
    a_cycle(0, 0, 8'h00, 1, 0);
    chk("a_burst count", int'(a_count), 5);
    a_cycle(1, 1, 8'hD0, 1, 0);
    a_chk("a_midrst");
    chk("a_midrst count", int'(a_count), 0);
    chk("a_midrst empty", int'(a_empty), 1);
    chk("a_midrst dout", int'(a_dout), 0);
    chk("a_midrst unf", int'(a_unf), 0);
    a_cycle(0, 1, 8'h77, 0, 0);
    chk("a_postrst count", int'(a_count), 1);
    a_cycle(0, 0, 8'h00, 1, 0);
    a_cycle(0, 0, 8'h00, 0, 0);
    chk("a_postrst dout", int'(a_dout), 8'h77);
    a_chk("a_end");

    // ---------------- Instance B ----------------
    b_cycle(1, 0, 8'h00, 0);
    b_cycle(1, 0, 8'h00, 0);
    b_chk("b_reset");
    chk("b_reset dout", int'(b_dout), 0);

    b_cycle(0, 1, 8'hA5, 0);
    chk("b_fwft empty", int'(b_empty), 0);
    chk("b_fwft dout", int'(b_dout), 8'hA5);
    b_cycle(0, 1, 8'hB6, 0);
    b_chk("b_second");
    b_cycle(0, 0, 8'h00, 1);
    chk("b_next dout", int'(b_dout), 8'hB6);
    b_cycle(0, 0, 8'h00, 1);
    b_chk("b_empty");
    b_cycle(0, 0, 8'h00, 1);
    chk("b_unf flag", int'(b_unf), 1);
    chk("b_unf count", int'(b_count), 0);

    for (int i = 0; i < 4; i++) begin
      b_cycle(0, 1, 8'(8'h10 + i), 0);
      b_chk("b_load");
    end
    for (int i = 0; i < 10; i++) begin
      b_cycle(0, 1, 8'(8'h20 + i), 1);
      b_chk("b_wrap");
    end
    b_cycle(0, 1, 8'h30, 0);
    b_cycle(0, 1, 8'h31, 0);
    b_chk("b_full");
    chk("b_full flag", int'(b_full), 1);
    b_cycle(0, 1, 8'h32, 0);
    b_chk("b_ovf");
    for (int i = 0; i < 6; i++) begin
      b_cycle(0, 0, 8'h00, 1);
      b_chk("b_drain");
    end

    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
